// File: rtl/rom_readback.sv
// rom_readback: reads a contiguous SDRAM byte region as 16-bit words and streams it out low byte first.
// Optional build macro ROM_READBACK_REORDER_64_EN adds reorder_64 to undo the loader's 64-byte interleave.
module rom_readback #(
    parameter int ADDR_W = 25,
    parameter int SIZE_W = 32
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [SIZE_W-1:0] size,
`ifdef ROM_READBACK_REORDER_64_EN
    input  logic              reorder_64,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-2:0] sdr_addr,
    output logic              sdr_req,
    input  logic              sdr_rdy,
    input  logic [15:0]       sdr_q,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LO,
        S_HI,
        S_FIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-2:0] base_q;
    logic [SIZE_W-1:0] size_q;
    logic [SIZE_W-1:0] offset;
    logic [15:0]       word_q;
    logic              zero_done;
    logic [ADDR_W-1:0] offset_a;
    logic [ADDR_W-2:0] word_off;
    logic              is_final;
    logic              accept;
    logic              unused_bits;

`ifdef ROM_READBACK_REORDER_64_EN
    logic              reorder_q;
`endif

    assign offset_a    = ADDR_W'(offset);
    assign is_final    = (offset == size_q - SIZE_W'(1));
    assign accept      = out_valid && out_ready;
    assign unused_bits = ^{base_addr[0], offset_a[0]};

    // Word offset within the region; the interleave swaps byte-offset bits so reads land in file order.
    always_comb begin
        word_off = offset_a[ADDR_W-1:1];
`ifdef ROM_READBACK_REORDER_64_EN
        if (reorder_q) begin
            word_off = {offset_a[ADDR_W-1:7], offset_a[5:2], offset_a[6], offset_a[1]};
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && (size != '0)) begin
                    state_next = S_REQ;
                end
            end
            S_REQ:  state_next = S_WAIT;
            S_WAIT: begin
                if (sdr_rdy) begin
                    state_next = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    state_next = is_final ? S_FIN : S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    state_next = is_final ? S_FIN : S_REQ;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        sdr_req   = 1'b0;
        done      = zero_done;
        case (state)
            S_REQ:  busy = 1'b1;
            S_WAIT: begin
                busy    = 1'b1;
                sdr_req = 1'b1;
            end
            S_LO: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = word_q[7:0];
            end
            S_HI: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = word_q[15:8];
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
        out_last = out_valid && is_final;
    end

    // A zero-length request never leaves IDLE; it only produces the one-cycle done pulse.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            base_q    <= '0;
            size_q    <= '0;
            offset    <= '0;
            word_q    <= '0;
            sdr_addr  <= '0;
            zero_done <= 1'b0;
`ifdef ROM_READBACK_REORDER_64_EN
            reorder_q <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            zero_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q    <= base_addr[ADDR_W-1:1];
                        size_q    <= size;
                        offset    <= '0;
                        zero_done <= (size == '0);
`ifdef ROM_READBACK_REORDER_64_EN
                        reorder_q <= reorder_64;
`endif
                    end
                end
                S_REQ:  sdr_addr <= base_q + word_off;
                S_WAIT: begin
                    if (sdr_rdy) begin
                        word_q <= sdr_q;
                    end
                end
                S_LO, S_HI: begin
                    if (accept) begin
                        offset <= offset + SIZE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_readback.sv
// tb_rom_readback: randomized and directed bench for rom_readback with an SDRAM responder and a
// byte-level reference model of the region contents.
module tb_rom_readback;

    localparam int ADDR_W = 25;
    localparam int SIZE_W = 32;

    logic              sys_clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [SIZE_W-1:0] size;
    logic              busy;
    logic              done;
    logic [ADDR_W-2:0] sdr_addr;
    logic              sdr_req;
    logic              sdr_rdy;
    logic [15:0]       sdr_q;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    int          n_checks;
    int          n_errors;
    logic [15:0] mem [0:1023];
    logic [7:0]  got_q[$];
    logic        last_q[$];
    logic [23:0] addr_log[$];
    int          done_count;
    int          busy_seen;
    int          valid_seen;
    int          stall_obs;
    int          lat_cycles;
    int          stall_left;
    logic [7:0]  stall_byte;
    bit          resp_en;
    bit          ready_rand;
    bit          spur_req;
    bit          hold_pend;
    logic [7:0]  hold_data;

    rom_readback #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .size      (size),
        .busy      (busy),
        .done      (done),
        .sdr_addr  (sdr_addr),
        .sdr_req   (sdr_req),
        .sdr_rdy   (sdr_rdy),
        .sdr_q     (sdr_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: byte i of a region is the byte at (even base + i) in the word-organised memory.
    function automatic logic [7:0] modelByte(input logic [ADDR_W-1:0] b, input int unsigned i);
        int unsigned w;
        logic [15:0] word;
        w    = ((int'(b) >> 1) + (i >> 1)) % 1024;
        word = mem[w];
        return (i % 2 == 1) ? word[15:8] : word[7:0];
    endfunction

    // SDRAM responder: one read at a time, fixed latency, checks the request stays stable meanwhile.
    initial begin
        logic [23:0] req_addr;
        sdr_rdy = 1'b0;
        sdr_q   = 16'h0000;
        forever begin
            @(negedge sys_clk);
            if (spur_req) begin
                @(posedge sys_clk); #1;
                sdr_rdy = 1'b1;
                sdr_q   = 16'hDEAD;
                @(posedge sys_clk); #1;
                sdr_rdy  = 1'b0;
                spur_req = 1'b0;
            end else if (resp_en && sdr_req) begin
                req_addr = sdr_addr;
                addr_log.push_back(req_addr);
                for (int i = 0; i < lat_cycles; i++) begin
                    @(negedge sys_clk);
                    checkOutput("addr_stable", sdr_addr, req_addr);
                    checkOutput("req_held", sdr_req, 1);
                end
                @(posedge sys_clk); #1;
                sdr_rdy = 1'b1;
                sdr_q   = mem[req_addr[9:0]];
                @(posedge sys_clk); #1;
                sdr_rdy = 1'b0;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge sys_clk); #1;
            if (stall_left > 0 && out_valid && out_data == stall_byte) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (ready_rand) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Stream monitor: collects accepted bytes and checks that an offered byte is never withdrawn.
    initial begin
        hold_pend = 1'b0;
        hold_data = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (!reset_n) begin
                hold_pend = 1'b0;
            end else begin
                if (done) begin
                    done_count++;
                    checkOutput("done_busy_low", busy, 0);
                end
                if (busy) busy_seen++;
                if (out_valid) begin
                    valid_seen++;
                    if (hold_pend) checkOutput("hold_data", out_data, hold_data);
                    if (out_ready) begin
                        got_q.push_back(out_data);
                        last_q.push_back(out_last);
                        hold_pend = 1'b0;
                    end else begin
                        hold_pend = 1'b1;
                        hold_data = out_data;
                        stall_obs++;
                        checkOutput("no_req_stall", sdr_req, 0);
                    end
                end else if (hold_pend) begin
                    checkOutput("retract", out_valid, 1);
                    hold_pend = 1'b0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [ADDR_W-1:0] b, input int unsigned sz,
                                 input int lat, input bit rr);
        int unsigned n_words;
        got_q.delete();
        last_q.delete();
        addr_log.delete();
        done_count = 0;
        busy_seen  = 0;
        valid_seen = 0;
        stall_obs  = 0;
        lat_cycles = lat;
        ready_rand = rr;
        @(posedge sys_clk); #1;
        start     = 1'b1;
        base_addr = b;
        size      = sz;
        @(posedge sys_clk); #1;
        start = 1'b0;
        @(negedge sys_clk);
        checkOutput("busy_after_start", busy, sz != 0);
        for (int i = 0; i < 4000; i++) begin
            if (done_count != 0) break;
            @(posedge sys_clk);
        end
        checkOutput("done_seen", done_count != 0, 1);
        repeat (3) @(negedge sys_clk);
        checkOutput("done_once", done_count, 1);
        checkOutput("busy_idle", busy, 0);
        checkOutput("byte_count", got_q.size(), sz);
        for (int i = 0; i < got_q.size() && i < int'(sz); i++) begin
            checkOutput("byte", got_q[i], modelByte(b, i));
            checkOutput("last", last_q[i], i == int'(sz) - 1);
        end
        n_words = (sz + 1) / 2;
        checkOutput("req_count", addr_log.size(), n_words);
        for (int k = 0; k < addr_log.size() && k < int'(n_words); k++) begin
            checkOutput("addr", addr_log[k], ((int'(b) >> 1) + k) % (1 << 24));
        end
        if (sz == 0) begin
            checkOutput("zero_no_valid", valid_seen, 0);
            checkOutput("zero_no_busy", busy_seen, 0);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        size       = '0;
        resp_en    = 1'b1;
        ready_rand = 1'b0;
        spur_req   = 1'b0;
        stall_left = 0;
        stall_byte = 8'h00;
        lat_cycles = 1;
        done_count = 0;
        busy_seen  = 0;
        valid_seen = 0;
        stall_obs  = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);

        repeat (3) @(negedge sys_clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_req", sdr_req, 0);
        checkOutput("rst_addr", sdr_addr, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_last", out_last, 0);
        @(posedge sys_clk); #1;
        reset_n = 1'b1;

        mem[10'h080] = 16'hBBAA;
        mem[10'h081] = 16'hDDCC;
        applyStimulus(25'h100, 4, 2, 0);
        checkOutput("t1_bytes", {got_q[0], got_q[1], got_q[2], got_q[3]}, 32'hAABBCCDD);
        checkOutput("t1_addrs", {addr_log[0][15:0], addr_log[1][15:0]}, 32'h00800081);
        checkOutput("t1_last_dd", last_q[3], 1);

        mem[10'h000] = 16'hBBAA;
        mem[10'h001] = 16'hDDCC;
        applyStimulus(25'h000, 3, 1, 0);
        checkOutput("t2_bytes", {got_q[0], got_q[1], got_q[2]}, 32'h00AABBCC);
        checkOutput("t2_last_cc", last_q[2], 1);

        applyStimulus(25'h200, 0, 1, 0);

        stall_byte = 8'hBB;
        stall_left = 5;
        applyStimulus(25'h100, 4, 1, 0);
        checkOutput("stall_cycles", stall_obs, 5);
        checkOutput("stall_bytes", {got_q[0], got_q[1], got_q[2], got_q[3]}, 32'hAABBCCDD);

        spur_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!spur_req) break;
            @(posedge sys_clk);
        end
        @(negedge sys_clk);
        checkOutput("spur_busy", busy, 0);
        checkOutput("spur_valid", out_valid, 0);
        applyStimulus(25'h100, 4, 10, 0);
        checkOutput("slow_bytes", {got_q[0], got_q[1], got_q[2], got_q[3]}, 32'hAABBCCDD);

        applyStimulus(25'h1FFFFFE, 6, 0, 1);
        applyStimulus(25'h0000101, 5, 1, 1);

        repeat (25) begin
            applyStimulus(25'($urandom_range(0, 2047)), $urandom_range(0, 20),
                          $urandom_range(0, 4), 1);
        end

        resp_en    = 1'b0;
        ready_rand = 1'b0;
        @(posedge sys_clk); #1;
        start     = 1'b1;
        base_addr = 25'h40;
        size      = 4;
        @(posedge sys_clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (sdr_req) break;
        end
        checkOutput("wait_req_up", sdr_req, 1);
        checkOutput("wait_addr", sdr_addr, 24'h20);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_req", sdr_req, 0);
        checkOutput("midrst_addr", sdr_addr, 0);
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_done", done, 0);
        @(posedge sys_clk); #1;
        reset_n  = 1'b1;
        spur_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!spur_req) break;
            @(posedge sys_clk);
        end
        @(negedge sys_clk);
        checkOutput("late_rdy_busy", busy, 0);
        checkOutput("late_rdy_valid", out_valid, 0);
        checkOutput("late_rdy_req", sdr_req, 0);
        resp_en = 1'b1;
        applyStimulus(25'h40, 4, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
